// File: rtl/jam_pkg.sv
// Shared definitions for the job-assignment cost table: sizes, FSM states and the stored entry format.
// Optional build macro COST_PARITY_EN adds a parity bit to every stored entry.
package jam_pkg;

   localparam int N_WORK      = 8;
   localparam int COST_W      = 7;
   localparam int IDX_W       = 3;
   localparam int TABLE_DEPTH = N_WORK * N_WORK;
   localparam int ADDR_W      = 2 * IDX_W;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
`ifdef COST_PARITY_EN
      logic              par;
`endif
      logic [COST_W-1:0] cost;
   } cost_entry_t;

`ifdef COST_PARITY_EN
   // Stored parity is even parity over the cost bits, so a good entry XORs to zero overall.
   function automatic logic entry_bad(input cost_entry_t e);
      return e.par != (^e.cost);
   endfunction
`endif

endpackage

// File: rtl/jam_cost_rf.sv
// 64-entry cost register file: one synchronous write port, one asynchronous read port, synchronous clear.
// Entry width follows cost_entry_t, so it grows by one bit when COST_PARITY_EN is defined.
module jam_cost_rf
   import jam_pkg::*;
(
   input  logic              clk,
   input  logic              clr,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  cost_entry_t       wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output cost_entry_t       rd_data
);

   cost_entry_t mem [TABLE_DEPTH];

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < TABLE_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/jam_cost_table.sv
// Cost-matrix feeder for the job-assignment engine: loads 8x8 costs, releases the engine, serves lookups.
// Optional build macro COST_PARITY_EN adds in_par/par_err and per-entry parity checking.
module jam_cost_table
   import jam_pkg::*;
(
   input  logic              CLK,
   input  logic              RST,
   input  logic              in_valid,
   input  logic [COST_W-1:0] in_data,
   output logic              in_ready,
   input  logic [IDX_W-1:0]  W,
   input  logic [IDX_W-1:0]  J,
   output logic [COST_W-1:0] Cost,
   input  logic              jam_valid,
   output logic              jam_rst,
   output logic              table_ready,
   output logic [ADDR_W-1:0] load_cnt
`ifdef COST_PARITY_EN
   ,
   input  logic              in_par,
   output logic              par_err
`endif
);

   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        last_word;
   cost_entry_t wr_entry;
   cost_entry_t rd_entry;

   assign accept    = in_valid && in_ready;
   assign last_word = (load_cnt == ADDR_W'(TABLE_DEPTH - 1));

   always_comb begin
      wr_entry      = '0;
      wr_entry.cost = in_data;
`ifdef COST_PARITY_EN
      wr_entry.par  = in_par;
`endif
   end

   // Row-major address {W,J} selects entry W*N_WORK+J without a multiplier.
   jam_cost_rf u_rf (
      .clk     (CLK),
      .clr     (RST),
      .wr_en   (accept),
      .wr_addr (load_cnt),
      .wr_data (wr_entry),
      .rd_addr ({W, J}),
      .rd_data (rd_entry)
   );

   always_comb begin
      next_state = state;
      case (state)
         LOAD:    if (accept && last_word) next_state = RUN;
         RUN:     if (jam_valid) next_state = DRAIN;
         DRAIN:   next_state = LOAD;
         default: next_state = LOAD;
      endcase
   end

   // Handshake/engine-control outputs are decoded from next_state so they line up with the state register.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= LOAD;
         load_cnt    <= '0;
         in_ready    <= 1'b1;
         jam_rst     <= 1'b1;
         table_ready <= 1'b0;
      end else begin
         state       <= next_state;
         if (accept) begin
            load_cnt <= load_cnt + 1'b1;
         end
         in_ready    <= (next_state == LOAD);
         jam_rst     <= (next_state != RUN);
         table_ready <= (next_state == RUN);
      end
   end

   assign Cost = (state == RUN) ? rd_entry.cost : '0;

`ifdef COST_PARITY_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         par_err <= 1'b0;
      end else if (state == DRAIN) begin
         par_err <= 1'b0;
      end else if ((accept && (in_par != (^in_data))) ||
                   ((state == RUN) && entry_bad(rd_entry))) begin
         par_err <= 1'b1;
      end
   end
`endif

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream feeder for the job-assignment engine.
- Accepts an 8x8 cost matrix over a valid/ready stream, in row-major order (worker-major).
- Holds the matrix in a register file and answers the engine's (W,J) lookups combinationally, in the same cycle.
- Holds the engine in reset until the matrix is complete, then releases it; returns to loading once the engine reports Valid.

Parameters:
- N_WORK, 8, number of workers/jobs (matrix is N_WORK x N_WORK)
- COST_W, 7, bits per cost entry
- IDX_W, 3, index width for W/J (log2 N_WORK)

Ports:
- CLK  input  1  clock; all logic on rising edge
- RST  input  1  reset; synchronous and active-high
- in_valid  input  1  cost word present on in_data
- in_data  input  COST_W  cost entry; arrival order (W0,J0),(W0,J1)..(W7,J7)
- in_ready  output  1  table accepts a word this cycle
- W  input  IDX_W  worker index from engine
- J  input  IDX_W  job index from engine
- Cost  output  COST_W  entry [W][J], combinational
- jam_valid  input  1  engine's Valid (result done)
- jam_rst  output  1  reset to engine; high while table not ready
- table_ready  output  1  matrix complete, engine running
- load_cnt  output  2*IDX_W  entries accepted so far in current load

Behaviour:
- States: LOAD, RUN, DRAIN. Reset state is LOAD.
- Reset values: load_cnt=0, table_ready=0, jam_rst=1, all entries=0.
  - in_ready=1 from the first cycle after reset.
- Reset mid-load or mid-run: state goes to LOAD, load_cnt=0, entries cleared; any partial matrix is discarded.
- LOAD:
  - in_ready=1, jam_rst=1, table_ready=0.
  - A word is accepted when in_valid&&in_ready. It is written to entry load_cnt (row = load_cnt[5:3], col = load_cnt[2:0]), and load_cnt increments.
  - On acceptance with load_cnt==N_WORK*N_WORK-1: next state RUN, load_cnt wraps to 0.
  - Gaps in in_valid are allowed; load_cnt holds during them.
- RUN:
  - in_ready=0; in_valid/in_data are ignored and not stored.
  - jam_rst=0 and table_ready=1, both registered. They take effect in the first cycle after the last word is accepted.
  - Next state is DRAIN when jam_valid=1.
- DRAIN:
  - One cycle; jam_rst=1, table_ready=0, in_ready=0.
  - Next state LOAD. Entries are retained until overwritten by the next load.
- jam_valid outside RUN is ignored.
- Cost:
  - = entry[W*N_WORK+J] in RUN, zero-latency.
  - Forced to 0 in LOAD and DRAIN, so the engine never sees partial data.
- Index arithmetic: W*N_WORK+J is formed by concatenation {W,J}; no multiplier.
- Simultaneous last-word acceptance and jam_valid in LOAD: the word is accepted and jam_valid is ignored.
- Registered outputs: in_ready, jam_rst, table_ready, load_cnt. Cost is the only combinational output.

Optional Feature:
- Macro: COST_PARITY_EN.
- Defined:
  - Adds input in_par (1 bit, even parity over in_data), stored per entry.
  - Adds output par_err (1 bit, sticky).
  - During RUN, each cycle in which the looked-up entry fails parity sets par_err.
  - A parity error during LOAD (in_par mismatch on an accepted word) also sets par_err.
  - par_err clears only on RST or on entry to LOAD from DRAIN.
- Undefined: no in_par/par_err ports, no parity storage; behaviour otherwise identical.

Decomposition:
- Shared package jam_pkg holds:
  - N_WORK, COST_W, IDX_W, and the derived TABLE_DEPTH = N_WORK*N_WORK;
  - the state encoding (LOAD=0, RUN=1, DRAIN=2);
  - the cost entry typedef, COST_W bits plus the optional parity bit.
- One natural sub-module, jam_cost_rf: 64-entry write-port/async-read register file with clear. The FSM and counters stay in jam_cost_table.

Test Plan:
- Reset then stream 64 words, entry k = k mod 128, in_valid held high:
  - in_ready=1 for 64 cycles;
  - table_ready and jam_rst flip the cycle after the 64th accept;
  - W=5,J=3 -> Cost=43.
- Stream with in_valid toggling 1/0 for 128 cycles:
  - load_cnt tracks accepts only;
  - RUN entered after exactly 64 accepts;
  - Cost at W=7,J=7 = 63.
- In RUN, drive in_valid=1 with in_data=127 for 10 cycles:
  - in_ready=0;
  - W=0,J=0 still returns the loaded value.
- In RUN, pulse jam_valid one cycle:
  - one DRAIN cycle with jam_rst=1 and Cost=0;
  - then LOAD with in_ready=1 and load_cnt=0.
- Assert RST after 30 accepted words:
  - load_cnt=0, next cycle in_ready=1;
  - after a fresh 64-word load, entry 0 holds its new value, not stale data.
- With COST_PARITY_EN defined, load entry 9 with a wrong in_par:
  - par_err=1 the next cycle and stays 1 through RUN;
  - par_err clears after DRAIN->LOAD.
